// File: rtl/spi_master_arb_if.sv
// spi_master_arb_if: client-side handshake bundle for the two-requester SPI master.
// The "master" modport is the requester side (drives requests and transmit bytes),
// the "slave" modport is the arbiter side (returns grant, completion and receive data).
interface spi_master_arb_if;
    logic [1:0] req;
    logic [7:0] tx_data0;
    logic [7:0] tx_data1;
    logic [1:0] gnt;
    logic [1:0] done;
    logic [7:0] rx_data;
    logic       busy;

    modport master (
        output req, tx_data0, tx_data1,
        input  gnt, done, rx_data, busy
    );

    modport slave (
        input  req, tx_data0, tx_data1,
        output gnt, done, rx_data, busy
    );
endinterface

// File: rtl/spi_master_arb.sv
// spi_master_arb: two-requester SPI master (mode 0, 8-bit, MSB first).
// Arbitrates between two clients, then frames one byte transfer with
// SETUP / SHIFT / HOLD / STOP phases, each phase timed in spi_scl half-periods
// of CLK_DIV clk cycles.
// Optional build macro SPI_ARB_FIXED_PRIO_EN: when defined, requester 0 always
// wins a tie; otherwise ties are resolved round-robin against the last grant.
module spi_master_arb #(
    parameter int CLK_DIV = 4
) (
    input  logic            clk,
    input  logic            rst,
    spi_master_arb_if.slave bus,
    output logic            spi_scl,
    output logic            spi_cs,
    output logic            mosi,
    input  logic            miso
);
    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_SHIFT,
        S_HOLD,
        S_STOP
    } state_t;

    state_t     r_state;
    logic [7:0] r_div;
    logic [2:0] r_bit_cnt;
    logic [7:0] r_shift;
    logic [1:0] r_gnt;
    logic [1:0] r_done;
    logic [7:0] r_rx;
    logic       r_busy;
    logic       r_scl;
    logic       r_cs;
    logic       r_mosi;
`ifndef SPI_ARB_FIXED_PRIO_EN
    logic       r_last_gnt;
`endif

    logic       w_pick;      // 0 = requester 0 wins, 1 = requester 1 wins
    logic [7:0] w_tx;
    logic       w_half_end;

    // Winner selection among the currently asserted requests.
    always_comb begin
        w_pick = 1'b0;
`ifdef SPI_ARB_FIXED_PRIO_EN
        w_pick = ~bus.req[0];
`else
        if (bus.req == 2'b11) begin
            w_pick = ~r_last_gnt;
        end else begin
            w_pick = ~bus.req[0];
        end
`endif
    end

    assign w_tx       = w_pick ? bus.tx_data1 : bus.tx_data0;
    assign w_half_end = (r_div == DIV_LAST);

    // Frame sequencer: arbitration, clock generation, shifting and framing.
    // Sampling miso on the rising spi_scl edge also shifts the register left,
    // so the next transmit bit sits in bit 7 ready for the following fall and
    // the received byte has assembled MSB-first by the eighth rise.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_div      <= 8'd0;
            r_bit_cnt  <= 3'd0;
            r_shift    <= 8'd0;
            r_gnt      <= 2'b00;
            r_done     <= 2'b00;
            r_rx       <= 8'h00;
            r_busy     <= 1'b0;
            r_scl      <= 1'b0;
            r_cs       <= 1'b1;
            r_mosi     <= 1'b0;
`ifndef SPI_ARB_FIXED_PRIO_EN
            r_last_gnt <= 1'b1;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_div <= 8'd0;
                    if (bus.req != 2'b00) begin
                        r_gnt      <= w_pick ? 2'b10 : 2'b01;
                        r_shift    <= w_tx;
                        r_cs       <= 1'b0;
                        r_mosi     <= w_tx[7];
                        r_busy     <= 1'b1;
`ifndef SPI_ARB_FIXED_PRIO_EN
                        r_last_gnt <= w_pick;
`endif
                        r_state    <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    if (w_half_end) begin
                        r_div   <= 8'd0;
                        r_state <= S_SHIFT;
                    end else begin
                        r_div <= r_div + 8'd1;
                    end
                end
                S_SHIFT: begin
                    if (w_half_end) begin
                        r_div <= 8'd0;
                        r_scl <= ~r_scl;
                        if (!r_scl) begin
                            r_shift <= {r_shift[6:0], miso};
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                            if (r_bit_cnt == 3'd7) begin
                                r_state <= S_HOLD;
                            end else begin
                                r_mosi <= r_shift[7];
                            end
                        end
                    end else begin
                        r_div <= r_div + 8'd1;
                    end
                end
                S_HOLD: begin
                    if (w_half_end) begin
                        r_div   <= 8'd0;
                        r_cs    <= 1'b1;
                        r_rx    <= r_shift;
                        r_done  <= r_gnt;
                        r_state <= S_STOP;
                    end else begin
                        r_div <= r_div + 8'd1;
                    end
                end
                S_STOP: begin
                    r_done <= 2'b00;
                    r_gnt  <= 2'b00;
                    if (w_half_end) begin
                        r_div   <= 8'd0;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_div <= r_div + 8'd1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.gnt     = r_gnt;
    assign bus.done    = r_done;
    assign bus.rx_data = r_rx;
    assign bus.busy    = r_busy;
    assign spi_scl     = r_scl;
    assign spi_cs      = r_cs;
    assign mosi        = r_mosi;
endmodule

// File: tb/tb_spi_master_arb.sv
// tb_spi_master_arb: randomized self-checking bench for spi_master_arb.
// A byte-level slave drives miso, a reference model predicts winners, frame
// timing, transmitted and received bytes from the protocol rules.
module tb_spi_master_arb;
    localparam int D     = 2;
    localparam int LIMIT = 60 * D + 40;

    logic clk = 1'b0;
    logic rst;
    logic spi_scl;
    logic spi_cs;
    logic mosi;
    logic miso;

    spi_master_arb_if bus();

    spi_master_arb #(.CLK_DIV(D)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .spi_scl (spi_scl),
        .spi_cs  (spi_cs),
        .mosi    (mosi),
        .miso    (miso)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Slave device model: shifts out slave_byte MSB first, next bit after each fall.
    logic [7:0] slave_byte = 8'h00;
    logic [2:0] sidx = 3'd0;
    assign miso = slave_byte[3'd7 - sidx];
    always @(negedge spi_cs) sidx = 3'd0;
    always @(negedge spi_scl) if (!spi_cs) sidx = sidx + 3'd1;

    // Mode-0 receiver on the slave side: capture mosi on rising spi_scl.
    logic [7:0] mosi_bits = 8'h00;
    always @(posedge spi_scl) mosi_bits <= {mosi_bits[6:0], mosi};

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Sampled-bus monitors, updated once per tick on the falling clk edge.
    logic prev_scl = 1'b0, prev_cs = 1'b1, prev_mosi = 1'b0;
    int   scl_bad = 0, mosi_bad = 0, cs_busy_cnt = 0, rise_cnt = 0;

    task automatic tick();
        @(negedge clk);
        if (!rst) begin
            if (spi_cs && prev_cs && (spi_scl !== prev_scl)) scl_bad++;
            if (spi_scl && (mosi !== prev_mosi)) mosi_bad++;
        end
        if (spi_scl && !prev_scl) rise_cnt++;
        if (spi_cs && bus.busy) cs_busy_cnt++;
        prev_scl  = spi_scl;
        prev_cs   = spi_cs;
        prev_mosi = mosi;
    endtask

    // Reference arbitration model.
    int model_last = 1;
    int last_done_cyc = 0;
    int cs_busy_at_done = 0;
    int frame_no = 0;

    function automatic int pick(input logic [1:0] r, input int last);
`ifdef SPI_ARB_FIXED_PRIO_EN
        return r[0] ? 0 : 1;
`else
        if (r == 2'b11) return 1 - last;
        return r[0] ? 0 : 1;
`endif
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        model_last = 1;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (bus.busy && n < LIMIT) begin
            tick();
            n++;
        end
        if (bus.busy) check("idle_timeout", 32'd0, 32'd1);
    endtask

    // One complete frame: grant, optional mid-frame request drop, done and cleanup.
    task automatic run_frame(input int exp_idx, input logic [7:0] exp_tx, input logic [7:0] exp_rx,
                             input bit b2b, input int drop_after, input int exp_lat, input bit zero_tx);
        int n;
        int tg;
        int td;
        n = 0;
        while (bus.gnt == 2'b00 && n < LIMIT) begin
            tick();
            n++;
        end
        if (bus.gnt == 2'b00) begin
            check("grant_timeout", 32'd0, 32'd1);
            return;
        end
        tg = cyc;
        check("gnt", 32'(bus.gnt), 32'(1 << exp_idx));
        check("busy", 32'(bus.busy), 32'd1);
        check("cs_low_at_grant", 32'(spi_cs), 32'd0);
        if (exp_lat > 0) check("gnt_latency", n, exp_lat);
        if (b2b) begin
            check("b2b_grant_gap", tg - last_done_cyc, D + 1);
            check("cs_high_gap", cs_busy_cnt - cs_busy_at_done, D);
        end
        model_last = exp_idx;
        bus.tx_data0 = zero_tx ? 8'h00 : 8'($urandom);
        bus.tx_data1 = 8'($urandom);
        n = 0;
        while (bus.done == 2'b00 && n < LIMIT) begin
            tick();
            n++;
            if (drop_after > 0 && n == drop_after) bus.req[exp_idx] = 1'b0;
        end
        if (bus.done == 2'b00) begin
            check("done_timeout", 32'd0, 32'd1);
            return;
        end
        td = cyc;
        check("done_latency", td - tg, 18 * D);
        check("done", 32'(bus.done), 32'(1 << exp_idx));
        check("rx_data", 32'(bus.rx_data), 32'(exp_rx));
        check("mosi_byte", 32'(mosi_bits), 32'(exp_tx));
        check("cs_high_at_done", 32'(spi_cs), 32'd1);
        $display("[TB] frame %0d: req%0d tx=%02h rx=%02h lat=%0d b2b=%0d drop=%0d",
                 frame_no, exp_idx, exp_tx, bus.rx_data, td - tg, b2b, drop_after);
        frame_no++;
        last_done_cyc   = td;
        cs_busy_at_done = cs_busy_cnt - 1;
        bus.req[exp_idx] = 1'b0;
        tick();
        check("gnt_clear", 32'(bus.gnt), 32'd0);
        check("done_pulse", 32'(bus.done), 32'd0);
    endtask

    // Serve every pending request in model order; later frames must be back-to-back.
    task automatic serve_all(input bit random_drop);
        bit   first = 1'b1;
        int   w;
        int   drop;
        logic [7:0] etx;
        while (bus.req != 2'b00) begin
            w   = pick(bus.req, model_last);
            etx = (w == 1) ? bus.tx_data1 : bus.tx_data0;
            slave_byte = 8'($urandom);
            drop = (random_drop && $urandom_range(0, 1) == 1) ? int'($urandom_range(1, 17 * D)) : 0;
            run_frame(w, etx, slave_byte, !first, drop, first ? 1 : 0, 1'b0);
            first = 1'b0;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int n;
        int r0;
        int done_seen;
        bus.req = 2'b00;
        bus.tx_data0 = 8'h00;
        bus.tx_data1 = 8'h00;
        do_reset();
        tick();

        // Reset values.
        check("rst_gnt", 32'(bus.gnt), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_rx", 32'(bus.rx_data), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_scl", 32'(spi_scl), 32'd0);
        check("rst_cs", 32'(spi_cs), 32'd1);
        check("rst_mosi", 32'(mosi), 32'd0);

        // Single transfer A5 out, 5A in.
        bus.tx_data0 = 8'hA5;
        slave_byte = 8'h5A;
        bus.req = 2'b01;
        run_frame(0, 8'hA5, 8'h5A, 1'b0, 0, 1, 1'b0);

        // Simultaneous requests after reset, then another tie.
        wait_idle();
        do_reset();
        bus.tx_data0 = 8'($urandom);
        bus.tx_data1 = 8'($urandom);
        bus.req = 2'b11;
        serve_all(1'b0);
        wait_idle();
        bus.req = 2'b11;
        serve_all(1'b0);

        // Request dropped mid-SHIFT.
        wait_idle();
        bus.tx_data0 = 8'($urandom);
        slave_byte = 8'($urandom);
        bus.req = 2'b01;
        run_frame(0, bus.tx_data0, slave_byte, 1'b0, 8 * D, 1, 1'b0);

        // tx_data changed after grant: FF then 00.
        wait_idle();
        bus.tx_data0 = 8'hFF;
        slave_byte = 8'h3C;
        bus.req = 2'b01;
        run_frame(0, 8'hFF, 8'h3C, 1'b0, 0, 1, 1'b1);

        // Reset at the 4th rising spi_scl edge.
        wait_idle();
        bus.tx_data0 = 8'($urandom);
        bus.req = 2'b01;
        n = 0;
        while (bus.gnt == 2'b00 && n < LIMIT) begin
            tick();
            n++;
        end
        r0 = rise_cnt;
        n = 0;
        while (rise_cnt < r0 + 4 && n < LIMIT) begin
            tick();
            n++;
        end
        check("abort_reached_rise4", rise_cnt - r0, 4);
        rst = 1'b1;
        tick();
        check("abort_cs", 32'(spi_cs), 32'd1);
        check("abort_scl", 32'(spi_scl), 32'd0);
        check("abort_gnt", 32'(bus.gnt), 32'd0);
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_done", 32'(bus.done), 32'd0);
        rst = 1'b0;
        bus.req = 2'b00;
        model_last = 1;
        done_seen = 0;
        repeat (20 * D) begin
            tick();
            if (bus.done != 2'b00) done_seen++;
        end
        check("abort_no_done", done_seen, 0);
        bus.tx_data0 = 8'($urandom);
        slave_byte = 8'($urandom);
        bus.req = 2'b01;
        run_frame(0, bus.tx_data0, slave_byte, 1'b0, 0, 1, 1'b0);

        // Randomized request patterns.
        repeat (14) begin
            wait_idle();
            bus.tx_data0 = 8'($urandom);
            bus.tx_data1 = 8'($urandom);
            bus.req = 2'($urandom_range(1, 3));
            serve_all(1'b1);
        end
        wait_idle();

        check("scl_edges_while_cs_high", scl_bad, 0);
        check("mosi_change_while_scl_high", mosi_bad, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
